// File: rtl/adder_share_arb_if.sv
// Bundle between the two requesters, the shared external adder and the arbiter.
// Optional ADDARB_OVF_EN adds the res_ovf signal.
interface adder_share_arb_if #(
    parameter int unsigned WIDTH = 16
);
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             gnt0;
    logic             done0;

    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt1;
    logic             done1;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;

    logic [WIDTH-1:0] res;
    logic             res_cout;
    logic             res_id;
`ifdef ADDARB_OVF_EN
    logic             res_ovf;
`endif

    // Arbiter side.
    modport slave (
        input  req0, a0, b0, req1, a1, b1, add_s, add_cout,
        output gnt0, done0, gnt1, done1, add_a, add_b, res, res_cout, res_id
`ifdef ADDARB_OVF_EN
        , output res_ovf
`endif
    );

    // Requesters plus the external adder.
    modport master (
        output req0, a0, b0, req1, a1, b1, add_s, add_cout,
        input  gnt0, done0, gnt1, done1, add_a, add_b, res, res_cout, res_id
`ifdef ADDARB_OVF_EN
        , input res_ovf
`endif
    );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one external WIDTH-bit adder between two requesters.
// Optional macro ADDARB_OVF_EN registers a signed-overflow flag alongside the sum.
module adder_share_arb #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    adder_share_arb_if.slave   bus
);
    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_q;
    logic             owner_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] res_q;
    logic             res_cout_q;
    logic             res_id_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             done0_q;
    logic             done1_q;

    logic any_req_c;
    logic pick_c;

    // Lone requester wins; on contention the one that did not go last wins.
    assign any_req_c = bus.req0 | bus.req1;
    assign pick_c    = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

`ifdef ADDARB_OVF_EN
    logic res_ovf_q;
    logic ovf_c;

    assign ovf_c = (op_a_q[MSB] == op_b_q[MSB]) && (bus.add_s[MSB] != op_a_q[MSB]);
`endif

    // Operand regs double as the adder drive: non-zero only while in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_q      <= '0;
            res_cout_q <= 1'b0;
            res_id_q   <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
`ifdef ADDARB_OVF_EN
            res_ovf_q  <= 1'b0;
`endif
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_c) begin
                        owner_q <= pick_c;
                        last_q  <= pick_c;
                        op_a_q  <= pick_c ? bus.a1 : bus.a0;
                        op_b_q  <= pick_c ? bus.b1 : bus.b0;
                        gnt0_q  <= ~pick_c;
                        gnt1_q  <= pick_c;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_q      <= bus.add_s;
                    res_cout_q <= bus.add_cout;
                    res_id_q   <= owner_q;
`ifdef ADDARB_OVF_EN
                    res_ovf_q  <= ovf_c;
`endif
                    op_a_q     <= '0;
                    op_b_q     <= '0;
                    done0_q    <= ~owner_q;
                    done1_q    <= owner_q;
                    state_q    <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.add_a    = op_a_q;
    assign bus.add_b    = op_b_q;
    assign bus.res      = res_q;
    assign bus.res_cout = res_cout_q;
    assign bus.res_id   = res_id_q;
`ifdef ADDARB_OVF_EN
    assign bus.res_ovf  = res_ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb with a result scoreboard and a behavioural
// external adder; res_ovf is checked only when ADDARB_OVF_EN is defined.
module tb_adder_share_arb;
    localparam int unsigned W = 16;

    logic clk;
    logic rst;

    adder_share_arb_if #(.WIDTH(W)) bus ();

    adder_share_arb #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // The shared adder lives outside the DUT.
    assign {bus.add_cout, bus.add_s} = 17'(bus.add_a) + 17'(bus.add_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   gcyc[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ngnt  = 0;
    int   ndone = 0;

    function automatic exp_t model(logic id, logic [W-1:0] a, logic [W-1:0] b);
        exp_t     r;
        logic [W:0] t;
        t    = {1'b0, a} + {1'b0, b};
        r.id = id;
        r.a  = a;
        r.b  = b;
        r.s  = t[W-1:0];
        r.c  = t[W];
        r.v  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic set_ops(logic id, logic [W-1:0] a, logic [W-1:0] b);
        if (id) begin
            bus.a1 = a;
            bus.b1 = b;
        end else begin
            bus.a0 = a;
            bus.b0 = b;
        end
    endtask

    task automatic set_req(logic id, logic v);
        if (id) bus.req1 = v;
        else    bus.req0 = v;
    endtask

    // One clock: sample at the falling edge, run protocol and scoreboard checks.
    task automatic cycle();
        exp_t e;
        logic id;
        @(negedge clk);
        cyc++;
        chk("gnt_mutex",  32'(bus.gnt0 & bus.gnt1), 32'd0);
        chk("done_mutex", 32'(bus.done0 & bus.done1), 32'd0);
        chk("gnt_done",   32'((bus.gnt0 | bus.gnt1) & (bus.done0 | bus.done1)), 32'd0);
        if (bus.gnt0 | bus.gnt1) begin
            id = bus.gnt1;
            ngnt++;
            gcyc.push_back(cyc);
            if (sb.size() != 0) begin
                chk("gnt_id", 32'(id), 32'(sb[0].id));
                chk("add_a",  32'(bus.add_a), 32'(sb[0].a));
                chk("add_b",  32'(bus.add_b), 32'(sb[0].b));
            end else begin
                chk("gnt_unexpected", 32'(ngnt), 32'd0);
            end
        end else begin
            chk("idle_add_zero", {bus.add_a, bus.add_b}, 32'd0);
        end
        if (bus.done0 | bus.done1) begin
            id = bus.done1;
            ndone++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_id",  32'(id), 32'(e.id));
                chk("res",      32'(bus.res), 32'(e.s));
                chk("res_cout", 32'(bus.res_cout), 32'(e.c));
                chk("res_id",   32'(bus.res_id), 32'(e.id));
`ifdef ADDARB_OVF_EN
                chk("res_ovf",  32'(bus.res_ovf), 32'(e.v));
`endif
            end else begin
                chk("done_unexpected", 32'(ndone), 32'd0);
            end
        end
    endtask

    task automatic run_until(int tg, int td, int budget);
        int n;
        n = budget;
        while ((ngnt < tg || ndone < td) && n > 0) begin
            cycle();
            n--;
        end
        chk("wait_timeout", 32'(ngnt >= tg && ndone >= td), 32'd1);
    endtask

    task automatic op(logic id, logic [W-1:0] a, logic [W-1:0] b);
        int   c0, tg, td;
        exp_t m;
        m = model(id, a, b);
        sb.push_back(m);
        set_ops(id, a, b);
        set_req(id, 1'b1);
        c0 = cyc;
        tg = ngnt + 1;
        td = ndone;
        run_until(tg, td, 10);
        chk("gnt_latency", 32'(cyc - c0), 32'd1);
        // Requester may drop req and scramble operands in its grant cycle.
        set_req(id, 1'b0);
        set_ops(id, W'($urandom), W'($urandom));
        set_ops(~id, W'($urandom), W'($urandom));
        run_until(tg, td + 1, 10);
        chk("done_latency", 32'(cyc - c0), 32'd2);
        set_ops(id, W'($urandom), W'($urandom));
        cycle();
        chk("res_hold", 32'(bus.res), 32'(m.s));
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_res"},  32'(bus.res), 32'd0);
        chk({tag, "_cout"}, 32'(bus.res_cout), 32'd0);
        chk({tag, "_id"},   32'(bus.res_id), 32'd0);
        chk({tag, "_pulses"}, 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1}), 32'd0);
`ifdef ADDARB_OVF_EN
        chk({tag, "_ovf"},  32'(bus.res_ovf), 32'd0);
`endif
    endtask

    initial begin
        int g0, d0, st, g;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        rst = 1'b1;
        cycle();
        cycle();
        chk_reset_vals("reset");
        rst = 1'b0;

        op(1'b0, 16'h0001, 16'h0002);
        op(1'b1, 16'hFFFF, 16'h0001);
        op(1'b0, 16'h7FFF, 16'h0001);
        op(1'b1, 16'h8000, 16'h8000);
        op(1'b0, 16'h0003, 16'h0004);

        // Request pulse that never sees a rising edge must be ignored.
        g = ngnt;
        bus.req0 = 1'b1;
        #2;
        bus.req0 = 1'b0;
        repeat (4) cycle();
        chk("glitch_no_gnt", 32'(ngnt), 32'(g));

        repeat (5) begin
            set_ops(1'b0, W'($urandom), W'($urandom));
            set_ops(1'b1, W'($urandom), W'($urandom));
            cycle();
        end

        // Fairness: both requesters held across four operations.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_ops(1'b0, 16'h1111, 16'h0F0F);
        set_ops(1'b1, 16'hA5A5, 16'h5A5A);
        sb.push_back(model(1'b0, 16'h1111, 16'h0F0F));
        sb.push_back(model(1'b1, 16'hA5A5, 16'h5A5A));
        sb.push_back(model(1'b0, 16'h1111, 16'h0F0F));
        sb.push_back(model(1'b1, 16'hA5A5, 16'h5A5A));
        g0 = ngnt;
        d0 = ndone;
        st = gcyc.size();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        run_until(g0 + 4, d0, 40);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        run_until(g0 + 4, d0 + 4, 10);
        for (int i = 1; i < 4; i++) begin
            if (gcyc.size() > st + i)
                chk("fair_gap", 32'(gcyc[st + i] - gcyc[st + i - 1]), 32'd3);
            else
                chk("fair_gap_missing", 32'(gcyc.size()), 32'(st + i + 1));
        end
        chk("fair_res_before_abort", 32'(bus.res), 32'h0000FFFF);

        // Reset during EXEC aborts the operation with no done pulse.
        set_ops(1'b0, 16'h1234, 16'h1111);
        sb.push_back(model(1'b0, 16'h1234, 16'h1111));
        bus.req0 = 1'b1;
        run_until(ngnt + 1, ndone, 10);
        rst = 1'b1;
        cycle();
        chk_reset_vals("abort");
        chk("abort_add_zero", {bus.add_a, bus.add_b}, 32'd0);
        sb.delete();
        sb.push_back(model(1'b0, 16'h1234, 16'h1111));
        rst = 1'b0;
        g0 = cyc;
        run_until(ngnt + 1, ndone, 10);
        chk("regrant_latency", 32'(cyc - g0), 32'd1);
        bus.req0 = 1'b0;
        run_until(ngnt, ndone + 1, 10);
        chk("regrant_res", 32'(bus.res), 32'h00002345);

        repeat (3) cycle();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
